// File: rtl/dds_fm_sequencer.sv
// Square-wave FM sequencer: alternates a DDS tuning word between centre+dev
// and centre-dev with blanking and integration windows in each half-cycle.
module dds_fm_sequencer #(
    parameter int FREQ_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [FREQ_W-1:0] cfg_center,
    input  logic [FREQ_W-1:0] cfg_dev,
    input  logic [CNT_W-1:0]  cfg_settle,
    input  logic [CNT_W-1:0]  cfg_integ,
    input  logic [CNT_W-1:0]  cfg_ncyc,
    input  logic              cfg_update,
    output logic [FREQ_W-1:0] dds_freq,
    output logic              half_sel,
    output logic              integ_en,
    output logic              cycle_done,
    output logic              seq_done,
    output logic              cfg_ack,
    output logic              busy,
    output logic              sat_err
);

    typedef enum logic [2:0] {
        IDLE,
        SET_HI,
        INT_HI,
        SET_LO,
        INT_LO
    } state_t;

    state_t state;
    state_t nstate;
    state_t first;

    logic [CNT_W-1:0]  tmr;
    logic [CNT_W-1:0]  ntmr;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  cyc_next;

    logic [FREQ_W-1:0] s_center;
    logic [FREQ_W-1:0] s_dev;
    logic [CNT_W-1:0]  s_settle;
    logic [CNT_W-1:0]  s_integ;
    logic [CNT_W-1:0]  s_ncyc;

    logic              pend;
    logic [FREQ_W-1:0] p_center;
    logic [FREQ_W-1:0] p_dev;
    logic [CNT_W-1:0]  p_settle;
    logic [CNT_W-1:0]  p_integ;
    logic [CNT_W-1:0]  p_ncyc;

    logic [FREQ_W-1:0] e_center;
    logic [FREQ_W-1:0] e_dev;
    logic [CNT_W-1:0]  e_settle;
    logic [CNT_W-1:0]  e_integ;
    logic [CNT_W-1:0]  e_ncyc;

    logic [FREQ_W:0]   hi_sum;
    logic [FREQ_W:0]   lo_dif;
    logic [FREQ_W-1:0] e_hi;
    logic [FREQ_W-1:0] e_lo;
    logic              e_sat;

    logic [CNT_W-1:0]  settle_len;
    logic [CNT_W-1:0]  integ_len;

    logic load_start;
    logic last;
    logic fin;
    logic boundary;
    logic apply;
    logic end_pulse;

    // Effective config is the shadow set except on the two load points,
    // so every transition can use the same length and word sources.
    always_comb begin
        load_start = (state == IDLE) && start && !stop;
        last       = (tmr == '0);
        cyc_next   = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CNT_W'(1);
        fin        = (s_ncyc != '0) && (cyc_next >= s_ncyc);
        boundary   = (state == INT_LO) && last && !stop && !fin;
        apply      = boundary && pend;

        e_center = s_center;
        e_dev    = s_dev;
        e_settle = s_settle;
        e_integ  = s_integ;
        e_ncyc   = s_ncyc;
        if (load_start) begin
            e_center = cfg_center;
            e_dev    = cfg_dev;
            e_settle = cfg_settle;
            e_integ  = cfg_integ;
            e_ncyc   = cfg_ncyc;
        end else if (apply) begin
            e_center = p_center;
            e_dev    = p_dev;
            e_settle = p_settle;
            e_integ  = p_integ;
            e_ncyc   = p_ncyc;
        end

        hi_sum = {1'b0, e_center} + {1'b0, e_dev};
        lo_dif = {1'b0, e_center} - {1'b0, e_dev};
        e_hi   = hi_sum[FREQ_W] ? '1 : hi_sum[FREQ_W-1:0];
        e_lo   = lo_dif[FREQ_W] ? '0 : lo_dif[FREQ_W-1:0];
        e_sat  = hi_sum[FREQ_W] | lo_dif[FREQ_W];

        settle_len = e_settle - CNT_W'(1);
        integ_len  = (e_integ == '0) ? '0 : e_integ - CNT_W'(1);
        first      = (e_settle != '0) ? SET_HI : INT_HI;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:   nstate = load_start ? first : IDLE;
            SET_HI: if (last) nstate = INT_HI;
            INT_HI: if (last) nstate = (s_settle != '0) ? SET_LO : INT_LO;
            SET_LO: if (last) nstate = INT_LO;
            INT_LO: if (last) nstate = fin ? IDLE : first;
            default: nstate = IDLE;
        endcase
        if (stop)
            nstate = IDLE;

        ntmr = '0;
        if (nstate == IDLE)
            ntmr = '0;
        else if (nstate == state)
            ntmr = tmr - CNT_W'(1);
        else if (nstate == SET_HI || nstate == SET_LO)
            ntmr = settle_len;
        else
            ntmr = integ_len;

        end_pulse = (nstate == INT_LO) && (ntmr == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            cyc_cnt    <= '0;
            s_center   <= '0;
            s_dev      <= '0;
            s_settle   <= '0;
            s_integ    <= '0;
            s_ncyc     <= '0;
            pend       <= 1'b0;
            p_center   <= '0;
            p_dev      <= '0;
            p_settle   <= '0;
            p_integ    <= '0;
            p_ncyc     <= '0;
            dds_freq   <= '0;
            half_sel   <= 1'b0;
            integ_en   <= 1'b0;
            cycle_done <= 1'b0;
            seq_done   <= 1'b0;
            cfg_ack    <= 1'b0;
            busy       <= 1'b0;
            sat_err    <= 1'b0;
        end else begin
            state <= nstate;
            tmr   <= ntmr;

            if (load_start || apply) begin
                s_center <= e_center;
                s_dev    <= e_dev;
                s_settle <= e_settle;
                s_integ  <= e_integ;
                s_ncyc   <= e_ncyc;
            end

            if (load_start)
                cyc_cnt <= '0;
            else if (state == INT_LO && last && !stop)
                cyc_cnt <= cyc_next;

            // An update arriving on the boundary clock waits for the next one.
            if (state != IDLE && nstate == IDLE) begin
                pend <= 1'b0;
            end else if (state != IDLE && cfg_update) begin
                pend     <= 1'b1;
                p_center <= cfg_center;
                p_dev    <= cfg_dev;
                p_settle <= cfg_settle;
                p_integ  <= cfg_integ;
                p_ncyc   <= cfg_ncyc;
            end else if (apply) begin
                pend <= 1'b0;
            end

            unique case (nstate)
                SET_HI, INT_HI: dds_freq <= e_hi;
                SET_LO, INT_LO: dds_freq <= e_lo;
                default:        dds_freq <= e_center;
            endcase

            half_sel   <= (nstate == SET_LO) || (nstate == INT_LO);
            integ_en   <= (nstate == INT_HI) || (nstate == INT_LO);
            busy       <= (nstate != IDLE);
            cycle_done <= end_pulse;
            seq_done   <= end_pulse && fin;
            cfg_ack    <= apply;

            if (load_start)
                sat_err <= e_sat;
            else if (apply && e_sat)
                sat_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dds_fm_sequencer.sv
// Directed bench for dds_fm_sequencer: timing of FM half-cycles,
// saturation, live update, stop and reset behaviour.
module tb_dds_fm_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] cfg_center = '0;
    logic [31:0] cfg_dev = '0;
    logic [15:0] cfg_settle = '0;
    logic [15:0] cfg_integ = '0;
    logic [15:0] cfg_ncyc = '0;
    logic        cfg_update = 1'b0;
    logic [31:0] dds_freq;
    logic        half_sel;
    logic        integ_en;
    logic        cycle_done;
    logic        seq_done;
    logic        cfg_ack;
    logic        busy;
    logic        sat_err;

    int n_cmp = 0;
    int n_bad = 0;
    int p;

    dds_fm_sequencer #(.FREQ_W(32), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .cfg_center(cfg_center),
        .cfg_dev(cfg_dev),
        .cfg_settle(cfg_settle),
        .cfg_integ(cfg_integ),
        .cfg_ncyc(cfg_ncyc),
        .cfg_update(cfg_update),
        .dds_freq(dds_freq),
        .half_sel(half_sel),
        .integ_en(integ_en),
        .cycle_done(cycle_done),
        .seq_done(seq_done),
        .cfg_ack(cfg_ack),
        .busy(busy),
        .sat_err(sat_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] c, input logic [31:0] d,
                           input logic [15:0] s, input logic [15:0] i,
                           input logic [15:0] n);
        cfg_center = c;
        cfg_dev    = d;
        cfg_settle = s;
        cfg_integ  = i;
        cfg_ncyc   = n;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_freq", dds_freq, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_integ", {31'b0, integ_en}, 32'h0);
        chk("rst_sat", {31'b0, sat_err}, 32'h0);
        chk("rst_half", {31'b0, half_sel}, 32'h0);

        // Two-cycle finite run
        set_cfg(32'h1000_0000, 32'h0010_0000, 16'd3, 16'd5, 16'd2);
        go();
        for (int k = 1; k <= 32; k++) begin
            p = (k - 1) % 16;
            chk($sformatf("r1_freq_%0d", k), dds_freq,
                (p < 8) ? 32'h1010_0000 : 32'h0FF0_0000);
            chk($sformatf("r1_integ_%0d", k), {31'b0, integ_en},
                {31'b0, ((p % 8) >= 3)});
            chk($sformatf("r1_half_%0d", k), {31'b0, half_sel},
                {31'b0, (p >= 8)});
            chk($sformatf("r1_cdone_%0d", k), {31'b0, cycle_done},
                {31'b0, (p == 15)});
            chk($sformatf("r1_sdone_%0d", k), {31'b0, seq_done},
                {31'b0, (k == 32)});
            chk($sformatf("r1_busy_%0d", k), {31'b0, busy}, 32'h1);
            tick();
        end
        chk("r1_busy_end", {31'b0, busy}, 32'h0);
        chk("r1_freq_end", dds_freq, 32'h1000_0000);

        // Zero settle and zero integ
        set_cfg(32'h0000_2000, 32'h0000_0100, 16'd0, 16'd0, 16'd1);
        go();
        chk("r2_c1_integ", {31'b0, integ_en}, 32'h1);
        chk("r2_c1_freq", dds_freq, 32'h0000_2100);
        chk("r2_c1_half", {31'b0, half_sel}, 32'h0);
        chk("r2_c1_cdone", {31'b0, cycle_done}, 32'h0);
        tick();
        chk("r2_c2_integ", {31'b0, integ_en}, 32'h1);
        chk("r2_c2_freq", dds_freq, 32'h0000_1F00);
        chk("r2_c2_half", {31'b0, half_sel}, 32'h1);
        chk("r2_c2_cdone", {31'b0, cycle_done}, 32'h1);
        chk("r2_c2_sdone", {31'b0, seq_done}, 32'h1);
        tick();
        chk("r2_c3_busy", {31'b0, busy}, 32'h0);
        chk("r2_c3_sdone", {31'b0, seq_done}, 32'h0);

        // Saturation, then clear on next start
        set_cfg(32'hFFFF_FFF0, 32'h0000_0020, 16'd1, 16'd1, 16'd1);
        go();
        chk("r3_hi_sat", dds_freq, 32'hFFFF_FFFF);
        chk("r3_sat", {31'b0, sat_err}, 32'h1);
        tick();
        tick();
        chk("r3_lo", dds_freq, 32'hFFFF_FFD0);
        tick();
        tick();
        chk("r3_idle", {31'b0, busy}, 32'h0);
        chk("r3_sat_hold", {31'b0, sat_err}, 32'h1);
        chk("r3_idle_freq", dds_freq, 32'hFFFF_FFF0);
        cfg_dev = 32'h0;
        go();
        chk("r3_sat_clr", {31'b0, sat_err}, 32'h0);
        chk("r3_hi_nodev", dds_freq, 32'hFFFF_FFF0);
        tick();
        tick();
        tick();
        tick();
        chk("r3_idle2", {31'b0, busy}, 32'h0);

        // Continuous run with live update (last wins)
        set_cfg(32'h1000_0000, 32'h0000_0010, 16'd2, 16'd3, 16'd0);
        go();
        tick();
        tick();
        cfg_dev = 32'h30;
        cfg_update = 1'b1;
        tick();
        cfg_dev = 32'h40;
        tick();
        cfg_update = 1'b0;
        cfg_dev = 32'h99;
        chk("r4_c5_freq", dds_freq, 32'h1000_0010);
        chk("r4_c5_ack", {31'b0, cfg_ack}, 32'h0);
        tick();
        tick();
        tick();
        chk("r4_c8_freq", dds_freq, 32'h0FFF_FFF0);
        chk("r4_c8_half", {31'b0, half_sel}, 32'h1);
        tick();
        tick();
        chk("r4_c10_cdone", {31'b0, cycle_done}, 32'h1);
        chk("r4_c10_sdone", {31'b0, seq_done}, 32'h0);
        chk("r4_c10_ack", {31'b0, cfg_ack}, 32'h0);
        chk("r4_c10_freq", dds_freq, 32'h0FFF_FFF0);
        tick();
        chk("r4_c11_freq", dds_freq, 32'h1000_0040);
        chk("r4_c11_ack", {31'b0, cfg_ack}, 32'h1);
        chk("r4_c11_half", {31'b0, half_sel}, 32'h0);
        chk("r4_c11_integ", {31'b0, integ_en}, 32'h0);
        tick();
        chk("r4_c12_ack", {31'b0, cfg_ack}, 32'h0);
        chk("r4_c12_freq", dds_freq, 32'h1000_0040);
        for (int k = 0; k < 6; k++) tick();
        chk("r4_c18_integ", {31'b0, integ_en}, 32'h1);
        chk("r4_c18_freq", dds_freq, 32'h0FFF_FFC0);

        // Stop during INT_LO
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("r5_busy", {31'b0, busy}, 32'h0);
        chk("r5_integ", {31'b0, integ_en}, 32'h0);
        chk("r5_freq", dds_freq, 32'h1000_0000);
        chk("r5_cdone", {31'b0, cycle_done}, 32'h0);
        chk("r5_half", {31'b0, half_sel}, 32'h0);
        tick();
        chk("r5_cdone2", {31'b0, cycle_done}, 32'h0);
        chk("r5_busy2", {31'b0, busy}, 32'h0);

        // Reset mid SET_LO with an update pending
        set_cfg(32'h3000_0000, 32'h0000_0100, 16'd4, 16'd2, 16'd0);
        go();
        chk("r6_c1_freq", dds_freq, 32'h3000_0100);
        tick();
        cfg_dev = 32'h200;
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("r6_c8_half", {31'b0, half_sel}, 32'h1);
        chk("r6_c8_freq", dds_freq, 32'h2FFF_FF00);
        rst = 1'b1;
        start = 1'b1;
        cfg_update = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        cfg_update = 1'b0;
        chk("r6_rst_freq", dds_freq, 32'h0);
        chk("r6_rst_busy", {31'b0, busy}, 32'h0);
        chk("r6_rst_half", {31'b0, half_sel}, 32'h0);
        chk("r6_rst_integ", {31'b0, integ_en}, 32'h0);
        chk("r6_rst_ack", {31'b0, cfg_ack}, 32'h0);
        chk("r6_rst_sat", {31'b0, sat_err}, 32'h0);

        // Stop wins over start in IDLE; update in IDLE is ignored
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("r7_stopwin", {31'b0, busy}, 32'h0);
        set_cfg(32'h0000_0500, 32'h0000_0010, 16'd1, 16'd1, 16'd1);
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        chk("r7_idle_upd", {31'b0, cfg_ack}, 32'h0);
        go();
        chk("r7_c1_freq", dds_freq, 32'h0000_0510);
        for (int k = 1; k <= 4; k++) begin
            start = (k == 2);
            chk($sformatf("r7_ack_%0d", k), {31'b0, cfg_ack}, 32'h0);
            chk($sformatf("r7_busy_%0d", k), {31'b0, busy}, 32'h1);
            chk($sformatf("r7_sdone_%0d", k), {31'b0, seq_done},
                {31'b0, (k == 4)});
            tick();
        end
        start = 1'b0;
        chk("r7_end_busy", {31'b0, busy}, 32'h0);
        chk("r7_end_freq", dds_freq, 32'h0000_0500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_fm_sequencer.md
DDS_FM_SEQUENCER -- requirements
Module: dds_fm_sequencer

Interface
REQ-001 Parameter FREQ_W, default 32: frequency control word width; it matches the DDS phase accumulator.
REQ-002 Parameter CNT_W, default 16: width of the settle, integrate and cycle counters.
REQ-003 Port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: level-sampled request to begin a sequence; honoured only in IDLE.
REQ-006 Port stop, input, 1: abort request; honoured in any state.
REQ-007 Port cfg_center, input, FREQ_W: centre frequency word.
REQ-008 Port cfg_dev, input, FREQ_W: frequency deviation word (unsigned).
REQ-009 Port cfg_settle, input, CNT_W: blanking clocks per half-cycle.
REQ-010 Port cfg_integ, input, CNT_W: integration clocks per half-cycle.
REQ-011 Port cfg_ncyc, input, CNT_W: full modulation cycles per run; 0 means continuous.
REQ-012 Port cfg_update, input, 1: single-clock pulse requesting a new configuration while busy.
REQ-013 Port dds_freq, output, FREQ_W: registered frequency word driving the DDS accumulator.
REQ-014 Port half_sel, output, 1: 0 means high half (centre+dev), 1 means low half (centre-dev).
REQ-015 Port integ_en, output, 1: high during integrate windows; it gates the demodulator.
REQ-016 Port cycle_done, output, 1: one-clock pulse at the end of each full cycle.
REQ-017 Port seq_done, output, 1: one-clock pulse when a finite run completes.
REQ-018 Port cfg_ack, output, 1: one-clock pulse when a pending update is applied.
REQ-019 Port busy, output, 1: high in every state except IDLE.
REQ-020 Port sat_err, output, 1: sticky flag indicating a saturated frequency computation.

Function
REQ-021 The FSM SHALL have states IDLE, SET_HI, INT_HI, SET_LO, INT_LO, and every output SHALL be registered.
REQ-022 In IDLE with start=1 and stop=0, the block SHALL latch all cfg_* inputs into shadow registers and enter SET_HI on the next clock.
REQ-023 hi_word SHALL equal center+dev and lo_word SHALL equal center-dev, both computed from the shadow registers in FREQ_W+1 bits.
REQ-024 On carry, hi_word SHALL saturate to all-ones; on borrow, lo_word SHALL saturate to zero; either event SHALL set sat_err, which clears only on rst or on the next accepted start.
REQ-025 In SET_HI and INT_HI, dds_freq SHALL equal hi_word and half_sel SHALL be 0; in SET_LO and INT_LO, dds_freq SHALL equal lo_word and half_sel SHALL be 1; in IDLE, dds_freq SHALL hold the shadow centre word.
REQ-026 The first clock of SET_HI SHALL show hi_word on dds_freq, i.e. one clock after start is sampled.
REQ-027 Each SET_x state SHALL last exactly cfg_settle clocks; if cfg_settle=0, the SET_x state SHALL be skipped and the FSM SHALL go directly to INT_x.
REQ-028 Each INT_x state SHALL last exactly max(cfg_integ,1) clocks, with integ_en=1 throughout and 0 in all other states.
REQ-029 On the last clock of INT_LO, the block SHALL raise cycle_done and increment the cycle counter; the counter SHALL saturate and never wrap.
REQ-030 If cfg_ncyc≠0 and the cycle count reaches cfg_ncyc, the block SHALL pulse seq_done together with cycle_done and return to IDLE; otherwise it SHALL return to SET_HI.
REQ-031 A cfg_update pulse while busy SHALL set a pending flag that samples the cfg_* inputs at that clock.
REQ-032 A pending update SHALL be applied only at a cycle boundary (INT_LO→SET_HI) and SHALL pulse cfg_ack there; the cycle counter SHALL not reset.
REQ-033 Further cfg_update pulses before the boundary SHALL overwrite the pending values (last wins).
REQ-034 cfg_update in IDLE SHALL be ignored, with no cfg_ack.
REQ-035 stop=1 in any busy state SHALL force IDLE on the next clock; integ_en SHALL drop immediately, no cycle_done or seq_done pulse SHALL be generated, and any pending update SHALL be discarded.
REQ-036 stop and start asserted together in IDLE SHALL leave the block in IDLE (stop wins).
REQ-037 start asserted while busy SHALL be ignored.

Reset
REQ-038 rst=1 SHALL, at the clock edge, force IDLE and clear all counters, shadow registers, the pending flag, dds_freq, half_sel, integ_en, cycle_done, seq_done, cfg_ack, busy and sat_err, regardless of the current state.
REQ-039 When rst=1 coincides with start, stop or cfg_update, rst SHALL take precedence.

Verification
REQ-040 Run: center=0x1000_0000, dev=0x0010_0000, settle=3, integ=5, ncyc=2 -> dds_freq 0x1010_0000 for 8 clocks, then 0x0FF0_0000 for 8 clocks; integ_en high for 5 of each 8; cycle_done at clocks 16 and 32 after start; seq_done with the second; busy low at clock 33.
REQ-041 Run: settle=0, integ=0, ncyc=1 -> exactly 1 INT_HI clock and 1 INT_LO clock; seq_done on clock 2.
REQ-042 Run: center=0xFFFF_FFF0, dev=0x20 -> hi_word=0xFFFF_FFFF, lo_word=0xFFFF_FFD0, sat_err=1; a later start with dev=0 clears sat_err.
REQ-043 Run: ncyc=0 with cfg_update (dev=0x40) mid INT_HI -> old words until the cycle boundary; new words and cfg_ack exactly on the first SET_HI clock after it.
REQ-044 Run: stop asserted during INT_LO -> next clock is IDLE; integ_en=0; dds_freq=center; no cycle_done.
REQ-045 Run: rst pulsed for 1 clock mid SET_LO with cfg_update pending -> all outputs zero; start then behaves as from power-up, with no cfg_ack.
